// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The optional memory-ready input exists only when MCC_MEM_WAIT_EN is defined.
interface multicycle_ctrl_if #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32
);
  logic [OP_W-1:0]     instr_op_i;
  logic                zero_i;
`ifdef MCC_MEM_WAIT_EN
  logic                mem_ready_i;
`endif
  logic                pc_write_o;
  logic [1:0]          pc_src_o;
  logic                ir_write_o;
  logic                i_or_d_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                mem_to_reg_o;
  logic                reg_dst_o;
  logic                reg_write_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [3:0]          state_o;
  logic                illegal_o;
  logic [CNT_W-1:0]    retire_cnt_o;

  // Controller side: consumes opcode/flags, drives all datapath controls.
  modport slave (
`ifdef MCC_MEM_WAIT_EN
    input  mem_ready_i,
`endif
    input  instr_op_i, zero_i,
    output pc_write_o, pc_src_o, ir_write_o, i_or_d_o, mem_read_o,
           mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           retire_cnt_o
  );

  // Datapath side: supplies opcode/flags, observes the controls.
  modport master (
`ifdef MCC_MEM_WAIT_EN
    output mem_ready_i,
`endif
    output instr_op_i, zero_i,
    input  pc_write_o, pc_src_o, ir_write_o, i_or_d_o, mem_read_o,
           mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           retire_cnt_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, flags illegal opcodes and
// counts retired instructions. Define MCC_MEM_WAIT_EN to let FETCH, MEMRD
// and MEMWR stall on mem_ready_i.
module multicycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'h0a);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2b);

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3'b011);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_ready_s;
  logic                retire_s;

  logic                pc_write_s;
  logic [1:0]          pc_src_s;
  logic                ir_write_s;
  logic                i_or_d_s;
  logic                mem_read_s;
  logic                mem_write_s;
  logic                mem_to_reg_s;
  logic                reg_dst_s;
  logic                reg_write_s;
  logic                alu_src_a_s;
  logic [1:0]          alu_src_b_s;
  logic [ALU_OP_W-1:0] alu_op_s;
  logic                illegal_s;

`ifdef MCC_MEM_WAIT_EN
  assign mem_ready_s = bus.mem_ready_i;
`else
  assign mem_ready_s = 1'b1;
`endif

  // Next-state, opcode capture and Moore output decode for the current state.
  always_comb begin
    state_d      = S_FETCH;
    op_d         = op_q;
    retire_s     = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'b00;
    ir_write_s   = 1'b0;
    i_or_d_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_dst_s    = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = ALU_ADD;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        // IR/PC only load in the cycle the memory actually returns data.
        if (mem_ready_s) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_s = 2'b11;
        op_d        = bus.instr_op_i;
        case (bus.instr_op_i)
          OP_R:             state_d = S_RTEXE;
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_ADDI, OP_SLTI: state_d = S_IEXE;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (op_q == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (mem_ready_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        // A store retires only in the cycle the write is accepted.
        if (mem_ready_s) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_RTEXE: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_FUNCT;
        state_d     = S_RTWB;
      end
      S_RTWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (op_q == OP_SLTI) begin
          alu_op_s = ALU_SLT;
        end else begin
          alu_op_s = ALU_ADD;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_SUB;
        pc_src_s    = 2'b01;
        pc_write_s  = bus.zero_i;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_s   = 2'b10;
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      // Encodings 12-15 are unreachable; recover to FETCH with outputs idle.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter next value; wraps naturally at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, latched opcode and retire counter; reset aborts any instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset masks every control immediately so no write can complete.
  assign bus.pc_write_o   = rst_i ? 1'b0 : pc_write_s;
  assign bus.pc_src_o     = rst_i ? 2'b00 : pc_src_s;
  assign bus.ir_write_o   = rst_i ? 1'b0 : ir_write_s;
  assign bus.i_or_d_o     = rst_i ? 1'b0 : i_or_d_s;
  assign bus.mem_read_o   = rst_i ? 1'b0 : mem_read_s;
  assign bus.mem_write_o  = rst_i ? 1'b0 : mem_write_s;
  assign bus.mem_to_reg_o = rst_i ? 1'b0 : mem_to_reg_s;
  assign bus.reg_dst_o    = rst_i ? 1'b0 : reg_dst_s;
  assign bus.reg_write_o  = rst_i ? 1'b0 : reg_write_s;
  assign bus.alu_src_a_o  = rst_i ? 1'b0 : alu_src_a_s;
  assign bus.alu_src_b_o  = rst_i ? 2'b00 : alu_src_b_s;
  assign bus.alu_op_o     = rst_i ? ALU_ADD : alu_op_s;
  assign bus.illegal_o    = rst_i ? 1'b0 : illegal_s;
  assign bus.state_o      = state_q;
  assign bus.retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by a
// random instruction stream, each cycle compared with a per-instruction model.
module tb_multicycle_ctrl;

  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } outs_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [TB_CNT_W-1:0] exp_cnt;
  outs_t obs_s;

  multicycle_ctrl_if #(.OP_W(6), .ALU_OP_W(3), .CNT_W(TB_CNT_W)) bus ();

  multicycle_ctrl #(.OP_W(6), .ALU_OP_W(3), .CNT_W(TB_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign obs_s = {bus.pc_write_o, bus.pc_src_o, bus.ir_write_o, bus.i_or_d_o,
                  bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o,
                  bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o,
                  bus.alu_src_b_o, bus.alu_op_o, bus.illegal_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check at the falling edge, then move just past the next rising edge.
  task automatic step(input string tag, input logic [3:0] st, input outs_t e);
    @(negedge clk);
    chk({tag, "/state"}, 32'(bus.state_o), 32'(st));
    chk({tag, "/outs"}, 32'(obs_s), 32'(e));
    chk({tag, "/retire"}, 32'(bus.retire_cnt_o), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  // Opcode and zero flag are garbage except where the instruction samples them.
  task automatic rnd_in();
    bus.instr_op_i = 6'($urandom);
    bus.zero_i     = 1'($urandom);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0a, 6'h23, 6'h2b};
  endfunction

  // Memory access phase; with waits enabled, nwait stall cycles precede the ready cycle.
  task automatic mem_phase(input string tag, input logic [3:0] st, input outs_t base,
                           input bit is_fetch, input int nwait);
    outs_t e;
`ifdef MCC_MEM_WAIT_EN
    for (int i = 0; i < nwait; i++) begin
      rnd_in();
      bus.mem_ready_i = 1'b0;
      step({tag, "_wait"}, st, base);
    end
    bus.mem_ready_i = 1'b1;
`endif
    rnd_in();
    e = base;
    if (is_fetch) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end else begin
      e.ir_write = 1'b0;
    end
    step(tag, st, e);
  endtask

  function automatic int pick_wait();
`ifdef MCC_MEM_WAIT_EN
    return int'($urandom_range(0, 2));
`else
    return 0;
`endif
  endfunction

  task automatic do_fetch(input int nwait);
    outs_t e;
    e = '0;
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    mem_phase("fetch", 4'd0, e, 1'b1, nwait);
  endtask

  task automatic do_decode(input logic [5:0] op);
    outs_t e;
    rnd_in();
    bus.instr_op_i = op;
    e = '0;
    e.alu_src_b = 2'b11;
    e.illegal   = !is_legal(op);
    step("decode", 4'd1, e);
  endtask

  // Full instruction from FETCH to retirement; zb is the zero flag for BEQ.
  task automatic run_instr(input logic [5:0] op, input logic zb);
    outs_t e;
    do_fetch(pick_wait());
    do_decode(op);
    if (is_legal(op)) begin
      e = '0;
      case (op)
        6'h23, 6'h2b: begin
          rnd_in();
          e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
          step("memadr", 4'd2, e);
          e = '0; e.i_or_d = 1'b1;
          if (op == 6'h23) begin
            e.mem_read = 1'b1;
            mem_phase("memrd", 4'd3, e, 1'b0, pick_wait());
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            rnd_in();
            step("memwb", 4'd4, e);
          end else begin
            e.mem_write = 1'b1;
            mem_phase("memwr", 4'd5, e, 1'b0, pick_wait());
          end
        end
        6'h00: begin
          rnd_in();
          e.alu_src_a = 1'b1; e.alu_op = 3'b010;
          step("rtexe", 4'd6, e);
          e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
          rnd_in();
          step("rtwb", 4'd7, e);
        end
        6'h08, 6'h0a: begin
          rnd_in();
          e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
          e.alu_op = (op == 6'h0a) ? 3'b011 : 3'b000;
          step("iexe", 4'd8, e);
          e = '0; e.reg_write = 1'b1;
          rnd_in();
          step("iwb", 4'd9, e);
        end
        6'h04: begin
          rnd_in();
          bus.zero_i = zb;
          e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_write = zb;
          step("branch", 4'd10, e);
        end
        default: begin
          rnd_in();
          e.pc_src = 2'b10; e.pc_write = 1'b1;
          step("jump", 4'd11, e);
        end
      endcase
      exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  logic [5:0] op_tab [0:11];

  initial begin
    outs_t e;
    logic [5:0] op;
    compared   = 0;
    mismatched = 0;
    exp_cnt    = '0;
    op_tab = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0a, 6'h04, 6'h02,
               6'h01, 6'h3f, 6'h10, 6'h22, 6'h05};
    rst = 1'b1;
    rnd_in();
`ifdef MCC_MEM_WAIT_EN
    bus.mem_ready_i = 1'b1;
`endif
    repeat (2) @(posedge clk);
    step("reset", 4'd0, '0);
    rst = 1'b0;

    // Directed: LW, BEQ taken/not taken, ADDI, SLTI, J, R-type, SW, illegal.
    run_instr(6'h23, 1'b0);
    run_instr(6'h04, 1'b1);
    run_instr(6'h04, 1'b0);
    run_instr(6'h08, 1'b0);
    run_instr(6'h0a, 1'b0);
    run_instr(6'h02, 1'b0);
    run_instr(6'h00, 1'b0);
    run_instr(6'h2b, 1'b0);
    run_instr(6'h3f, 1'b0);

`ifdef MCC_MEM_WAIT_EN
    // Three-cycle stall in FETCH, then a normal instruction.
    do_fetch(3);
    do_decode(6'h02);
    rnd_in();
    e = '0; e.pc_src = 2'b10; e.pc_write = 1'b1;
    step("jump_after_wait", 4'd11, e);
    exp_cnt = exp_cnt + 1'b1;
`endif

    // Random stream, long enough to wrap the narrow retire counter.
    for (int n = 0; n < 80; n++) begin
      op = op_tab[$urandom_range(0, 11)];
      run_instr(op, 1'($urandom));
    end

    // Asynchronous reset in the middle of MEMRD.
    do_fetch(0);
    do_decode(6'h23);
    rnd_in();
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    step("memadr_pre_rst", 4'd2, e);
    rnd_in();
    @(negedge clk);
    e = '0; e.mem_read = 1'b1; e.i_or_d = 1'b1;
    chk("memrd_pre_rst/outs", 32'(obs_s), 32'(e));
    #1;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    chk("rst_mid/state", 32'(bus.state_o), 32'd0);
    chk("rst_mid/outs", 32'(obs_s), 32'd0);
    chk("rst_mid/retire", 32'(bus.retire_cnt_o), 32'(exp_cnt));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(6'h23, 1'b0);
    run_instr(6'h2b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
